// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Holds the reset-PC default, the NOP encoding and the queue entry layout.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INS          = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits of a target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Circular queue of {pc, ins} pairs between the imem response port and IF_ID.
// Flush beats push; the head entry is read combinationally from storage.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [PW:0]  count,
  output fetch_entry_t head
);

  fetch_entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW:0]   count_reg, count_next;
  logic          pop_eff;
  logic          push_eff;

  assign pop_eff  = pop && (count_reg != '0);
  // A push into a full queue is only accepted alongside a pop.
  assign push_eff = push && ((count_reg != (PW+1)'(DEPTH)) || pop_eff);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push_eff) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop_eff)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push_eff, pop_eff})
        2'b10:   count_next = count_reg + (PW+1)'(1);
        2'b01:   count_next = count_reg - (PW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push_eff && !flush) mem[wr_ptr_reg] <= push_entry;
  end

  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues in-order imem requests under a
// credit limit, and queues returned {pc, ins} pairs for IF_ID; redirects drop in-flight data.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        IFID_stall,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_ins
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   resp_pc_reg, resp_pc_next;
  logic [OW-1:0] outstanding_reg, outstanding_next;
  logic [OW-1:0] drop_cnt_reg, drop_cnt_next;

  logic [PW:0]   count;
  logic [PW+1:0] in_flight;
  logic          credit_ok;
  logic          out_ok;
  logic          req_fire;
  logic          resp_fire;
  logic          drop_active;
  logic          push;
  logic          pop;
  logic [31:0]   target_pc;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Queued plus in-flight entries may never exceed DEPTH, so every response has a slot.
  assign in_flight = {1'b0, count} + (PW+2)'(outstanding_reg);
  assign credit_ok = in_flight < (PW+2)'(DEPTH);
  assign out_ok    = outstanding_reg < OW'(MAX_OUTSTANDING);

  assign imem_req_valid = !rst && !redirect_valid && out_ok && credit_ok;
  assign imem_req_addr  = fetch_pc_reg;

  assign req_fire    = imem_req_valid && imem_req_ready;
  assign resp_fire   = imem_resp_valid;
  assign drop_active = (drop_cnt_reg != '0);
  assign push        = resp_fire && !drop_active && !redirect_valid;
  assign pop         = if_valid && !IFID_stall;
  assign target_pc   = align_pc(redirect_pc);

  assign push_entry.pc  = resp_pc_reg;
  assign push_entry.ins = imem_resp_data;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    resp_pc_next     = resp_pc_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;

    case ({req_fire, resp_fire})
      2'b10:   outstanding_next = outstanding_reg + OW'(1);
      2'b01:   outstanding_next = outstanding_reg - OW'(1);
      default: outstanding_next = outstanding_reg;
    endcase

    if (redirect_valid) begin
      // Every request still in flight after this edge belongs to the old path.
      fetch_pc_next = target_pc;
      resp_pc_next  = target_pc;
      drop_cnt_next = outstanding_reg - OW'(resp_fire);
    end else begin
      if (req_fire) fetch_pc_next = fetch_pc_reg + 32'd4;
      if (push)     resp_pc_next  = resp_pc_reg + 32'd4;
      if (resp_fire && drop_active) drop_cnt_next = drop_cnt_reg - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_PC;
      resp_pc_reg     <= RESET_PC;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      resp_pc_reg     <= resp_pc_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  // Queue storage is not reset, so the head is masked while the queue is empty.
  assign if_valid = (count != '0);
  assign if_pc    = if_valid ? head.pc  : 32'h0;
  assign if_ins   = if_valid ? head.ins : NOP_INS;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, variable-latency instruction memory model.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        IFID_stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_ins;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .IFID_stall     (IFID_stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_ins         (if_ins)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction

  // Memory model: request seen in cycle k answers in cycle k+mem_lat, in order.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t q[$];
  int    mem_lat = 1;
  int    mem_cyc = 0;
  logic  resp_taken = 1'b0;

  always @(negedge clk) begin
    resp_taken = rst ? 1'b0 : imem_resp_valid;
    if (!rst && imem_req_valid && imem_req_ready)
      q.push_back('{addr: imem_req_addr, due: mem_cyc + mem_lat});
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end else begin
      #1;
      mem_cyc++;
      if (resp_taken && q.size() > 0) void'(q.pop_front());
      if (q.size() > 0 && q[0].due <= mem_cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = ins_of(q[0].addr);
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-18s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #3;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!if_valid && n < max_cyc) begin
      nxt();
      n++;
    end
    chk(tag, 32'(if_valid), 32'd1);
  endtask

  logic [31:0] exp_pc;
  int          n;

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    IFID_stall     = 1'b0;
    imem_req_ready = 1'b1;

    // 1: reset values, then a continuous stream from 0x3000
    nxt(); nxt(); nxt();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_ins", if_ins, 32'h0);
    rst = 1'b0;
    #1;
    chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t1_addr0", imem_req_addr, 32'h3000);
    chk("t1_c0_if_valid", 32'(if_valid), 32'd0);
    nxt();
    chk("t1_c1_if_valid", 32'(if_valid), 32'd0);
    chk("t1_addr1", imem_req_addr, 32'h3004);
    nxt();
    exp_pc = 32'h3000;
    chk("t1_c2_if_valid", 32'(if_valid), 32'd1);
    chk("t1_pc", if_pc, exp_pc);
    chk("t1_ins", if_ins, ins_of(exp_pc));
    for (int i = 0; i < 5; i++) begin
      nxt();
      exp_pc += 32'd4;
      chk("t1_stream_valid", 32'(if_valid), 32'd1);
      chk("t1_stream_pc", if_pc, exp_pc);
      chk("t1_stream_ins", if_ins, ins_of(exp_pc));
    end

    // 2: stall six cycles, queue fills to DEPTH, then drains in order
    nxt();
    exp_pc += 32'd4;
    IFID_stall = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) nxt();
      #1;
      chk("t2_hold_pc", if_pc, exp_pc);
    end
    chk("t2_count_full", 32'(dut.u_fifo.count_reg), 32'd4);
    chk("t2_req_blocked", 32'(imem_req_valid), 32'd0);
    nxt();
    IFID_stall = 1'b0;
    #1;
    chk("t2_credit_full", 32'(imem_req_valid), 32'd0);
    chk("t2_drain_pc", if_pc, exp_pc);
    for (int j = 0; j < 5; j++) begin
      nxt();
      exp_pc += 32'd4;
      chk("t2_drain_valid", 32'(if_valid), 32'd1);
      chk("t2_drain_pc", if_pc, exp_pc);
    end

    // 3: two requests in flight at latency 3, redirect drops both
    mem_lat = 3;
    n = 0;
    nxt();
    while (!(dut.outstanding_reg == 2 && !imem_resp_valid) && n < 20) begin
      nxt();
      n++;
    end
    chk("t3_two_out", 32'(dut.outstanding_reg), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4000;
    #1;
    chk("t3_no_req_redir", 32'(imem_req_valid), 32'd0);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("t3_drop_cnt", 32'(dut.drop_cnt_reg), 32'd2);
    chk("t3_flushed", 32'(if_valid), 32'd0);
    chk("t3_addr", imem_req_addr, 32'h4000);
    wait_valid("t3_wait_valid", 30);
    chk("t3_pc", if_pc, 32'h4000);
    chk("t3_ins", if_ins, ins_of(32'h4000));

    // 4: redirect with a same-cycle response and stall held
    mem_lat = 2;
    n = 0;
    nxt();
    while (!(dut.outstanding_reg == 2 && imem_resp_valid) && n < 20) begin
      nxt();
      n++;
    end
    chk("t4_two_out_resp", 32'(imem_resp_valid), 32'd1);
    IFID_stall     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h5000;
    #1;
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("t4_empty", 32'(if_valid), 32'd0);
    chk("t4_count", 32'(dut.u_fifo.count_reg), 32'd0);
    chk("t4_drop_cnt", 32'(dut.drop_cnt_reg), 32'd1);
    chk("t4_addr", imem_req_addr, 32'h5000);
    wait_valid("t4_wait_valid", 30);
    chk("t4_pc", if_pc, 32'h5000);
    chk("t4_ins", if_ins, ins_of(32'h5000));
    nxt();
    chk("t4_stall_hold", if_pc, 32'h5000);
    IFID_stall = 1'b0;
    #1;
    nxt();
    wait_valid("t4_wait_next", 30);
    chk("t4_next_pc", if_pc, 32'h5004);

    // 5: unaligned target is aligned; back-to-back redirects; PC wrap
    mem_lat = 1;
    nxt();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h4002;
    #1;
    chk("t5_no_req", 32'(imem_req_valid), 32'd0);
    nxt();
    redirect_pc = 32'hFFFF_FFFC;
    #1;
    chk("t5_aligned", imem_req_addr, 32'h4000);
    nxt();
    redirect_valid = 1'b0;
    #1;
    chk("t5_last_wins", imem_req_addr, 32'hFFFF_FFFC);
    n = 0;
    while (!imem_req_valid && n < 10) begin
      nxt();
      n++;
    end
    chk("t5_req_fire", 32'(imem_req_valid), 32'd1);
    nxt();
    chk("t5_wrap_addr", imem_req_addr, 32'h0);
    wait_valid("t5_wait_top", 30);
    chk("t5_top_pc", if_pc, 32'hFFFF_FFFC);
    chk("t5_top_ins", if_ins, ins_of(32'hFFFF_FFFC));
    nxt();
    wait_valid("t5_wait_zero", 30);
    chk("t5_zero_pc", if_pc, 32'h0);

    // 6: asynchronous reset mid-stream, then restart at 0x3000
    nxt();
    rst = 1'b1;
    #1;
    chk("t6_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_if_valid", 32'(if_valid), 32'd0);
    chk("t6_if_pc", if_pc, 32'h0);
    chk("t6_if_ins", if_ins, 32'h0);
    nxt();
    nxt();
    rst = 1'b0;
    #1;
    chk("t6_restart_addr", imem_req_addr, 32'h3000);
    chk("t6_restart_req", 32'(imem_req_valid), 32'd1);
    wait_valid("t6_wait_valid", 30);
    chk("t6_pc", if_pc, 32'h3000);
    chk("t6_ins", if_ins, ins_of(32'h3000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
